// File: rtl/axi_read_arbiter_pkg.sv
// Shared types for the two-master AXI read arbiter: FSM states, master ID tags
// and the registered AR beat.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [3:0] TAG_M0 = 4'h0;
  localparam logic [3:0] TAG_M1 = 4'h1;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_beat_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read channel (AR/R) bundle. ID_W is 4 on the master side and 8 on the
// slave side, where the master tag is prepended.
interface axi_read_arbiter_if #(parameter int ID_W = 4);

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_read_arbiter_pick2.sv
// Two-way winner select for the read arbiter. With AXI_RD_ARB_RR_EN defined a
// tie goes to the master not granted last; otherwise M1 always wins a tie.
module arb_pick2 (
  input  logic       req0,
  input  logic       req1,
`ifdef AXI_RD_ARB_RR_EN
  input  logic       last_m1,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
`ifdef AXI_RD_ARB_RR_EN
      gnt = last_m1 ? 2'b01 : 2'b10;
`else
      gnt = 2'b10;
`endif
    end else if (req1) begin
      gnt = 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between M0 (ifetch) and M1 (data load); one burst
// outstanding at a time. Build option: AXI_RD_ARB_RR_EN selects round-robin.
module axi_read_arbiter
  import axi_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s
);

  arb_state_t state, state_nxt;
  logic       grant, grant_nxt;
  ar_beat_t   ar_q, ar_nxt;
  logic [1:0] pick;
  logic       burst_done;
  logic       unused_rid_tag;

  assign unused_rid_tag = ^s.rid[7:4];

`ifdef AXI_RD_ARB_RR_EN
  logic last_m1;

  always_ff @(posedge clk) begin
    if (rst)             last_m1 <= 1'b1;
    else if (burst_done) last_m1 <= grant;
  end

  arb_pick2 u_pick (.req0(m0.arvalid), .req1(m1.arvalid), .last_m1(last_m1), .gnt(pick));
`else
  arb_pick2 u_pick (.req0(m0.arvalid), .req1(m1.arvalid), .gnt(pick));
`endif

  assign burst_done = !rst && (state == ST_DATA) && s.rvalid && s.rready && s.rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= 1'b0;
      ar_q  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ar_q  <= ar_nxt;
    end
  end

  // Every output is forced low while rst is high, whatever the registered state.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    ar_nxt     = ar_q;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rid     = '0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rid     = '0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;
    m1.rvalid  = 1'b0;
    s.arid     = '0;
    s.araddr   = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (pick[0]) begin
            m0.arready = 1'b1;
            ar_nxt     = '{id: {TAG_M0, m0.arid}, addr: m0.araddr, len: m0.arlen,
                           size: m0.arsize, burst: m0.arburst};
            grant_nxt  = 1'b0;
            state_nxt  = ST_ADDR;
          end else if (pick[1]) begin
            m1.arready = 1'b1;
            ar_nxt     = '{id: {TAG_M1, m1.arid}, addr: m1.araddr, len: m1.arlen,
                           size: m1.arsize, burst: m1.arburst};
            grant_nxt  = 1'b1;
            state_nxt  = ST_ADDR;
          end
        end
        ST_ADDR: begin
          s.arvalid = 1'b1;
          s.arid    = ar_q.id;
          s.araddr  = ar_q.addr;
          s.arlen   = ar_q.len;
          s.arsize  = ar_q.size;
          s.arburst = ar_q.burst;
          if (s.arready) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (!grant) begin
            m0.rvalid = s.rvalid;
            m0.rdata  = s.rdata;
            m0.rresp  = s.rresp;
            m0.rlast  = s.rlast;
            m0.rid    = s.rid[3:0];
            s.rready  = m0.rready;
          end else begin
            m1.rvalid = s.rvalid;
            m1.rdata  = s.rdata;
            m1.rresp  = s.rresp;
            m1.rlast  = s.rlast;
            m1.rid    = s.rid[3:0];
            s.rready  = m1.rready;
          end
          if (burst_done) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed + randomized bench for axi_read_arbiter with a transaction-level
// grant model; follows AXI_RD_ARB_RR_EN to pick the expected arbitration rule.
module tb_axi_read_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_read_arbiter_if #(.ID_W(4)) m0_if ();
  axi_read_arbiter_if #(.ID_W(4)) m1_if ();
  axi_read_arbiter_if #(.ID_W(8)) s_if ();

  axi_read_arbiter dut (.clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if));

  int n_cmp = 0;
  int n_err = 0;
  int last_m;
  int grant_log[$];

  bit          q_req[2];
  logic [3:0]  q_id[2];
  logic [31:0] q_addr[2];
  logic [3:0]  q_len[2];
  logic [2:0]  q_size[2];
  logic [1:0]  q_burst[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule stated at transaction level.
  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef AXI_RD_ARB_RR_EN
      return (last_m == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic drive_masters();
    m0_if.arvalid = q_req[0]; m0_if.arid = q_id[0]; m0_if.araddr = q_addr[0];
    m0_if.arlen = q_len[0]; m0_if.arsize = q_size[0]; m0_if.arburst = q_burst[0];
    m1_if.arvalid = q_req[1]; m1_if.arid = q_id[1]; m1_if.araddr = q_addr[1];
    m1_if.arlen = q_len[1]; m1_if.arsize = q_size[1]; m1_if.arburst = q_burst[1];
  endtask

  task automatic new_req(input int m, input logic [31:0] addr, input logic [3:0] id,
                         input logic [3:0] len);
    q_req[m] = 1'b1; q_id[m] = id; q_addr[m] = addr; q_len[m] = len;
    q_size[m] = 3'($urandom_range(0, 2)); q_burst[m] = 2'($urandom_range(0, 2));
  endtask

  task automatic ar_phase(input int stall, output int w);
    logic [7:0] exp_id;
    @(negedge clk);
    drive_masters();
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
    #1;
    w = model_pick(q_req[0], q_req[1]);
    grant_log.push_back(w);
    chk("arready_m0_idle", m0_if.arready, w == 0);
    chk("arready_m1_idle", m1_if.arready, w == 1);
    chk("arvalid_s_idle", s_if.arvalid, 0);
    exp_id = {(w == 1) ? 4'h1 : 4'h0, q_id[w]};
    q_req[w] = 1'b0;
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      drive_masters();
      s_if.arready = (c == stall);
      #1;
      chk("arvalid_s", s_if.arvalid, 1);
      chk("arid_s", s_if.arid, exp_id);
      chk("araddr_s", s_if.araddr, q_addr[w]);
      chk("arlen_s", s_if.arlen, q_len[w]);
      chk("arsize_s", s_if.arsize, q_size[w]);
      chk("arburst_s", s_if.arburst, q_burst[w]);
      chk("arready_m0_addr", m0_if.arready, 0);
      chk("arready_m1_addr", m1_if.arready, 0);
    end
  endtask

  // bp_mode: 0 = always ready, 1 = low every other cycle, 2 = random
  task automatic data_phase(input int w, input int nbeats, input int last_idx, input int bp_mode);
    int b = 0;
    int cyc = 0;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rdy;
    while (b < nbeats) begin
      @(negedge clk);
      drive_masters();
      s_if.arready = 1'b0;
      rd = $urandom;
      rr = 2'($urandom_range(0, 3));
      s_if.rvalid = 1'b1; s_if.rdata = rd; s_if.rresp = rr;
      s_if.rlast = (b == last_idx);
      s_if.rid = {(w == 1) ? 4'h1 : 4'h0, q_id[w]};
      rdy = (bp_mode == 1) ? cyc[0] : (bp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc > 4 * nbeats + 8) rdy = 1'b1;
      if (w == 0) begin m0_if.rready = rdy; m1_if.rready = 1'($urandom_range(0, 1)); end
      else        begin m1_if.rready = rdy; m0_if.rready = 1'($urandom_range(0, 1)); end
      #1;
      if (w == 0) begin
        chk("rvalid_m0", m0_if.rvalid, 1); chk("rdata_m0", m0_if.rdata, rd);
        chk("rresp_m0", m0_if.rresp, rr); chk("rlast_m0", m0_if.rlast, b == last_idx);
        chk("rid_m0", m0_if.rid, q_id[0]); chk("rvalid_m1_off", m1_if.rvalid, 0);
      end else begin
        chk("rvalid_m1", m1_if.rvalid, 1); chk("rdata_m1", m1_if.rdata, rd);
        chk("rresp_m1", m1_if.rresp, rr); chk("rlast_m1", m1_if.rlast, b == last_idx);
        chk("rid_m1", m1_if.rid, q_id[1]); chk("rvalid_m0_off", m0_if.rvalid, 0);
      end
      chk("rready_s", s_if.rready, rdy);
      chk("arready_m0_data", m0_if.arready, 0);
      chk("arready_m1_data", m1_if.arready, 0);
      if (rdy) b++;
      cyc++;
    end
  endtask

  task automatic full_read(input int stall, input int bp_mode);
    int w;
    ar_phase(stall, w);
    data_phase(w, int'(q_len[w]) + 1, int'(q_len[w]), bp_mode);
    last_m = w;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arready_m0"}, m0_if.arready, 0);
    chk({tag, "_arready_m1"}, m1_if.arready, 0);
    chk({tag, "_rvalid_m0"}, m0_if.rvalid, 0);
    chk({tag, "_rvalid_m1"}, m1_if.rvalid, 0);
    chk({tag, "_rdata_m0"}, m0_if.rdata, 0);
    chk({tag, "_rdata_m1"}, m1_if.rdata, 0);
    chk({tag, "_arvalid_s"}, s_if.arvalid, 0);
    chk({tag, "_arid_s"}, s_if.arid, 0);
    chk({tag, "_araddr_s"}, s_if.araddr, 0);
    chk({tag, "_rready_s"}, s_if.rready, 0);
  endtask

  initial begin
    int w;
    int first_tie;
    q_req = '{0, 0}; q_id = '{0, 0}; q_addr = '{0, 0};
    q_len = '{0, 0}; q_size = '{0, 0}; q_burst = '{0, 0};
    rst = 1'b1;
    drive_masters();
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0;
    s_if.rlast = 1'b0; s_if.rvalid = 1'b0;
    repeat (2) @(posedge clk);

    // Outputs stay zero under reset even with requests pending.
    @(negedge clk);
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1; s_if.rvalid = 1'b1; m0_if.rready = 1'b1;
    #1;
    check_all_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    drive_masters();
    s_if.rvalid = 1'b0;
    last_m = 1;

    // Three simultaneous requests back-to-back.
    for (int k = 0; k < 3; k++) begin
      if (!q_req[0]) new_req(0, 32'h1000 + 32'(k * 16), 4'(k), 4'($urandom_range(0, 2)));
      if (!q_req[1]) new_req(1, 32'h2000 + 32'(k * 16), 4'(k + 8), 4'($urandom_range(0, 2)));
      full_read(0, 0);
    end
`ifdef AXI_RD_ARB_RR_EN
    chk("tie_order_0", grant_log[0], 0);
    chk("tie_order_1", grant_log[1], 1);
    chk("tie_order_2", grant_log[2], 0);
`else
    chk("tie_order_0", grant_log[0], 1);
    chk("tie_order_1", grant_log[1], 1);
    chk("tie_order_2", grant_log[2], 1);
`endif
    while (q_req[0] || q_req[1]) full_read(0, 0);

    // Idle: no requests, slave R traffic must not leak to either master.
    @(negedge clk);
    drive_masters();
    s_if.rvalid = 1'b1; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    #1;
    check_all_zero("idle");

    // Single M0 read.
    new_req(0, 32'h0000_0040, 4'h3, 4'h0);
    full_read(0, 0);

    // M1 4-beat burst with alternating backpressure.
    new_req(1, 32'h0000_0100, 4'h5, 4'h3);
    full_read(0, 1);

    // AR stall of 5 cycles with the other master also requesting.
    new_req(0, 32'h0000_0200, 4'h6, 4'h1);
    new_req(1, 32'h0000_0300, 4'h7, 4'h0);
    full_read(5, 0);
    while (q_req[0] || q_req[1]) full_read(0, 0);

    // ID tagging.
    new_req(1, 32'h0000_0400, 4'hF, 4'h0);
    full_read(0, 0);

    // Randomized traffic.
    for (int k = 0; k < 25; k++) begin
      if (!q_req[0] && $urandom_range(0, 1)) new_req(0, $urandom, 4'($urandom), 4'($urandom_range(0, 3)));
      if (!q_req[1] && $urandom_range(0, 1)) new_req(1, $urandom, 4'($urandom), 4'($urandom_range(0, 3)));
      if (!q_req[0] && !q_req[1]) new_req(k % 2, $urandom, 4'($urandom), 4'($urandom_range(0, 3)));
      full_read($urandom_range(0, 3), 2);
    end
    while (q_req[0] || q_req[1]) full_read(0, 0);

    // Reset in the middle of a 4-beat burst.
    new_req(1, 32'h0000_0500, 4'h2, 4'h3);
    ar_phase(0, w);
    data_phase(w, 1, 3, 0);
    @(negedge clk);
    rst = 1'b1;
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1;
    s_if.rvalid = 1'b1; s_if.rlast = 1'b0; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    q_req = '{0, 0};
    drive_masters();
    last_m = 1;
    #1;
    check_all_zero("post_rst");
    new_req(0, 32'h0000_0600, 4'h1, 4'h0);
    new_req(1, 32'h0000_0700, 4'h9, 4'h0);
    first_tie = grant_log.size();
    full_read(0, 0);
`ifdef AXI_RD_ARB_RR_EN
    chk("post_rst_tie", grant_log[first_tie], 0);
`else
    chk("post_rst_tie", grant_log[first_tie], 1);
`endif
    while (q_req[0] || q_req[1]) full_read(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
